// File: rtl/mem_port_arbiter_if.sv
// Memory-side handshake of the arbiter: request, address and write data out;
// completion pulse and read data back.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic              mem_enable;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_data_out;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_data_in;

  modport master (
    output mem_enable, mem_rw, mem_addr, mem_data_out,
    input  mem_ack, mem_data_in
  );

  modport slave (
    input  mem_enable, mem_rw, mem_addr, mem_data_out,
    output mem_ack, mem_data_in
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I-cache fill, D-cache fill and D-cache write-back,
// one transaction at a time, fixed priority with an anti-starvation override for fetch.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | arbitrate masked requests, latch winner/addr/rw/data
// BUSY  | memory request held on the port until mem_ack
// RESP  | one-cycle ack to the winner, read line on both data outputs
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_read_req,
  input  logic [ADDR_W-1:0] ic_read_addr,
  output logic [LINE_W-1:0] ic_read_data,
  output logic              ic_read_ack,
  input  logic              dc_read_req,
  input  logic [ADDR_W-1:0] dc_read_addr,
  output logic [LINE_W-1:0] dc_read_data,
  output logic              dc_read_ack,
  input  logic              dc_write_req,
  input  logic [ADDR_W-1:0] dc_write_addr,
  input  logic [LINE_W-1:0] dc_write_data,
  output logic              dc_write_ack,
  mem_port_arbiter_if.master mem_if
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic [1:0] {WIN_IC, WIN_DR, WIN_DW} win_e;

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  state_e            state_q, state_d;
  win_e              win_q, win_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [2:0]        starve_q, starve_d;
  logic              mask_q, mask_d;

  logic ic_m, dr_m, dw_m;
  logic starve_hit;
  logic [2:0] starve_bump;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      win_q    <= WIN_IC;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      wdata_q  <= '0;
      line_q   <= '0;
      starve_q <= '0;
      mask_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
      line_q   <= line_d;
      starve_q <= starve_d;
      mask_q   <= mask_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    wdata_d  = wdata_q;
    line_d   = line_q;
    starve_d = starve_q;
    mask_d   = mask_q;

    // The previous winner is hidden for one IDLE cycle so a late-dropping req is not re-served.
    ic_m = ic_read_req  & ~(mask_q & (win_q == WIN_IC));
    dr_m = dc_read_req  & ~(mask_q & (win_q == WIN_DR));
    dw_m = dc_write_req & ~(mask_q & (win_q == WIN_DW));

    starve_hit  = ic_read_req && (starve_q == STARVE_MAX);
    starve_bump = (ic_read_req && (starve_q != STARVE_MAX)) ? starve_q + 3'd1
                : (ic_read_req ? starve_q : 3'd0);

    unique case (state_q)
      IDLE: begin
        mask_d = 1'b0;
        if (!ic_read_req) starve_d = '0;
        if (ic_m && starve_hit) begin
          win_d    = WIN_IC;
          addr_d   = ic_read_addr;
          rw_d     = 1'b0;
          wdata_d  = '0;
          starve_d = '0;
          state_d  = BUSY;
        end else if (dw_m) begin
          win_d    = WIN_DW;
          addr_d   = dc_write_addr;
          rw_d     = 1'b1;
          wdata_d  = dc_write_data;
          starve_d = starve_bump;
          state_d  = BUSY;
        end else if (dr_m) begin
          win_d    = WIN_DR;
          addr_d   = dc_read_addr;
          rw_d     = 1'b0;
          wdata_d  = '0;
          starve_d = starve_bump;
          state_d  = BUSY;
        end else if (ic_m) begin
          win_d    = WIN_IC;
          addr_d   = ic_read_addr;
          rw_d     = 1'b0;
          wdata_d  = '0;
          starve_d = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (mem_if.mem_ack) begin
          if (!rw_q) line_d = mem_if.mem_data_in;
          state_d = RESP;
        end
      end
      RESP: begin
        mask_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_if.mem_enable   = (state_q == BUSY);
  assign mem_if.mem_rw       = (state_q == BUSY) & rw_q;
  assign mem_if.mem_addr     = addr_q;
  assign mem_if.mem_data_out = wdata_q;

  assign ic_read_ack  = (state_q == RESP) && (win_q == WIN_IC);
  assign dc_read_ack  = (state_q == RESP) && (win_q == WIN_DR);
  assign dc_write_ack = (state_q == RESP) && (win_q == WIN_DW);
  assign ic_read_data = line_q;
  assign dc_read_data = line_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small memory model with programmable wait
// states answers the port; each scenario task checks cycle-exact behaviour inline.
module tb_mem_port_arbiter;

  logic         clk;
  logic         reset;
  logic         ic_read_req;
  logic [31:0]  ic_read_addr;
  logic [127:0] ic_read_data;
  logic         ic_read_ack;
  logic         dc_read_req;
  logic [31:0]  dc_read_addr;
  logic [127:0] dc_read_data;
  logic         dc_read_ack;
  logic         dc_write_req;
  logic [31:0]  dc_write_addr;
  logic [127:0] dc_write_data;
  logic         dc_write_ack;

  logic         model_ack;
  logic         stray_ack;
  logic [127:0] model_rdata;
  logic [127:0] rd_line;
  int           mem_wait;
  int           en_cnt;

  int n_checks;
  int n_fail;
  int n_ic, n_dr, n_dw;

  localparam logic [127:0] WB_DATA = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;

  mem_port_arbiter_if #(.ADDR_W(32), .LINE_W(128)) mem_if ();

  mem_port_arbiter #(.ADDR_W(32), .LINE_W(128), .STARVE_LIMIT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .ic_read_req   (ic_read_req),
    .ic_read_addr  (ic_read_addr),
    .ic_read_data  (ic_read_data),
    .ic_read_ack   (ic_read_ack),
    .dc_read_req   (dc_read_req),
    .dc_read_addr  (dc_read_addr),
    .dc_read_data  (dc_read_data),
    .dc_read_ack   (dc_read_ack),
    .dc_write_req  (dc_write_req),
    .dc_write_addr (dc_write_addr),
    .dc_write_data (dc_write_data),
    .dc_write_ack  (dc_write_ack),
    .mem_if        (mem_if)
  );

  assign mem_if.mem_ack     = model_ack | stray_ack;
  assign mem_if.mem_data_in = model_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers in the (mem_wait+1)-th BUSY cycle; read data is only the real line with ack.
  always @(negedge clk) begin
    if (mem_if.mem_enable) begin
      if (en_cnt == mem_wait) begin
        model_ack   = 1'b1;
        model_rdata = rd_line;
      end else begin
        model_ack   = 1'b0;
        model_rdata = ~rd_line;
      end
      en_cnt = en_cnt + 1;
    end else begin
      model_ack   = 1'b0;
      model_rdata = ~rd_line;
      en_cnt      = 0;
    end
  end

  always @(negedge clk) begin
    if (ic_read_ack)  n_ic = n_ic + 1;
    if (dc_read_ack)  n_dr = n_dr + 1;
    if (dc_write_ack) n_dw = n_dw + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (mem_if.mem_enable !== 1'b0 || mem_if.mem_rw !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: en=%b rw=%b, required 0 0", mem_if.mem_enable, mem_if.mem_rw);
    end
    n_checks++;
    if (mem_if.mem_addr !== 32'h0 || mem_if.mem_data_out !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_bus: addr=%h data=%h, required 0", mem_if.mem_addr, mem_if.mem_data_out);
    end
    n_checks++;
    if ({ic_read_ack, dc_read_ack, dc_write_ack} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_acks: %b, required 000", {ic_read_ack, dc_read_ack, dc_write_ack});
    end
    n_checks++;
    if (ic_read_data !== 128'h0 || dc_read_data !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: ic=%h dc=%h, required 0", ic_read_data, dc_read_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ic_fill();
    mem_wait     = 2;
    rd_line      = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    ic_read_req  = 1'b1;
    ic_read_addr = 32'h100;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_checks++;
      if (mem_if.mem_enable !== 1'b1 || mem_if.mem_rw !== 1'b0 || mem_if.mem_addr !== 32'h100) begin
        n_fail++;
        $display("FAIL ic_fill_busy c%0d: en=%b rw=%b addr=%h, required 1 0 100",
                 c, mem_if.mem_enable, mem_if.mem_rw, mem_if.mem_addr);
      end
      n_checks++;
      if (ic_read_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL ic_fill_early_ack c%0d: ack=%b, required 0", c, ic_read_ack);
      end
    end
    tick();
    n_checks++;
    if (ic_read_ack !== 1'b1 || ic_read_data !== rd_line) begin
      n_fail++;
      $display("FAIL ic_fill_ack: ack=%b data=%h, required 1 %h", ic_read_ack, ic_read_data, rd_line);
    end
    n_checks++;
    if (mem_if.mem_enable !== 1'b0 || dc_read_ack !== 1'b0 || dc_write_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL ic_fill_resp: en=%b dr=%b dw=%b, required 0 0 0",
               mem_if.mem_enable, dc_read_ack, dc_write_ack);
    end
    ic_read_req = 1'b0;
    tick();
    n_checks++;
    if (ic_read_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL ic_fill_pulse: ack=%b, required 0", ic_read_ack);
    end
    tick();
  endtask

  task automatic test_write_back();
    mem_wait      = 1;
    dc_write_req  = 1'b1;
    dc_write_addr = 32'h200;
    dc_write_data = WB_DATA;
    for (int c = 1; c <= 2; c++) begin
      tick();
      n_checks++;
      if (mem_if.mem_enable !== 1'b1 || mem_if.mem_rw !== 1'b1 || mem_if.mem_addr !== 32'h200
          || mem_if.mem_data_out !== WB_DATA) begin
        n_fail++;
        $display("FAIL wb_busy c%0d: en=%b rw=%b addr=%h data=%h, required 1 1 200 %h",
                 c, mem_if.mem_enable, mem_if.mem_rw, mem_if.mem_addr, mem_if.mem_data_out, WB_DATA);
      end
      n_checks++;
      if (dc_write_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL wb_early_ack c%0d: ack=%b, required 0", c, dc_write_ack);
      end
    end
    tick();
    n_checks++;
    if (dc_write_ack !== 1'b1 || ic_read_ack !== 1'b0 || dc_read_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_ack: dw=%b ic=%b dr=%b, required 1 0 0", dc_write_ack, ic_read_ack, dc_read_ack);
    end
    dc_write_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_all_three();
    logic [2:0]  drop;
    logic        exp_en;
    logic [31:0] exp_addr;
    int b_ic, b_dr, b_dw;
    b_ic = n_ic; b_dr = n_dr; b_dw = n_dw;
    mem_wait      = 0;
    rd_line       = 128'hCAFE0000_11110000_22220000_33330000;
    dc_write_req  = 1'b1; dc_write_addr = 32'h300; dc_write_data = ~WB_DATA;
    dc_read_req   = 1'b1; dc_read_addr  = 32'h400;
    ic_read_req   = 1'b1; ic_read_addr  = 32'h500;
    drop = 3'b000;
    for (int c = 1; c <= 9; c++) begin
      tick();
      // requesters with registered deassert drop req the cycle after their ack
      if (drop[0]) dc_write_req = 1'b0;
      if (drop[1]) dc_read_req  = 1'b0;
      if (drop[2]) ic_read_req  = 1'b0;
      drop     = 3'b000;
      exp_en   = (c == 1) || (c == 4) || (c == 7);
      exp_addr = (c == 1) ? 32'h300 : ((c == 4) ? 32'h400 : 32'h500);
      n_checks++;
      if (mem_if.mem_enable !== exp_en) begin
        n_fail++;
        $display("FAIL all3_en c%0d: en=%b, required %b", c, mem_if.mem_enable, exp_en);
      end
      if (exp_en) begin
        n_checks++;
        if (mem_if.mem_addr !== exp_addr) begin
          n_fail++;
          $display("FAIL all3_addr c%0d: addr=%h, required %h", c, mem_if.mem_addr, exp_addr);
        end
      end
      n_checks++;
      if ({dc_write_ack, dc_read_ack, ic_read_ack} !== {c == 2, c == 5, c == 8}) begin
        n_fail++;
        $display("FAIL all3_acks c%0d: dw/dr/ic=%b, required %b", c,
                 {dc_write_ack, dc_read_ack, ic_read_ack}, {c == 2, c == 5, c == 8});
      end
      drop = {ic_read_ack, dc_read_ack, dc_write_ack};
    end
    tick();
    n_checks++;
    if (n_ic - b_ic != 1 || n_dr - b_dr != 1 || n_dw - b_dw != 1) begin
      n_fail++;
      $display("FAIL all3_count: ic=%0d dr=%0d dw=%0d, required 1 1 1", n_ic - b_ic, n_dr - b_dr, n_dw - b_dw);
    end
    dc_write_req = 1'b0; dc_read_req = 1'b0; ic_read_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_starvation();
    logic [31:0] exp_order [10];
    logic        prev_en;
    int          g;
    exp_order = '{32'h600, 32'h700, 32'h600, 32'h700, 32'h800,
                  32'h600, 32'h700, 32'h600, 32'h700, 32'h800};
    mem_wait      = 0;
    dc_write_req  = 1'b1; dc_write_addr = 32'h600; dc_write_data = WB_DATA;
    dc_read_req   = 1'b1; dc_read_addr  = 32'h700;
    ic_read_req   = 1'b1; ic_read_addr  = 32'h800;
    prev_en = 1'b0;
    g = 0;
    for (int c = 0; c < 80 && g < 10; c++) begin
      tick();
      if (mem_if.mem_enable && !prev_en) begin
        n_checks++;
        if (mem_if.mem_addr !== exp_order[g]) begin
          n_fail++;
          $display("FAIL starve_grant %0d: addr=%h, required %h", g, mem_if.mem_addr, exp_order[g]);
        end
        g++;
      end
      prev_en = mem_if.mem_enable;
    end
    n_checks++;
    if (g != 10) begin
      n_fail++;
      $display("FAIL starve_timeout: grants=%0d, required 10", g);
    end
    dc_write_req = 1'b0; dc_read_req = 1'b0; ic_read_req = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_busy();
    int b_dr;
    b_dr         = n_dr;
    mem_wait     = 3;
    rd_line      = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
    dc_read_req  = 1'b1;
    dc_read_addr = 32'h900;
    tick();
    tick();
    n_checks++;
    if (mem_if.mem_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_busy_pre: en=%b, required 1", mem_if.mem_enable);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (mem_if.mem_enable !== 1'b0 || dc_read_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy_abort: en=%b ack=%b, required 0 0", mem_if.mem_enable, dc_read_ack);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (mem_if.mem_enable !== 1'b1 || mem_if.mem_addr !== 32'h900) begin
      n_fail++;
      $display("FAIL rst_busy_retry: en=%b addr=%h, required 1 900", mem_if.mem_enable, mem_if.mem_addr);
    end
    repeat (3) tick();
    n_checks++;
    if (n_dr != b_dr) begin
      n_fail++;
      $display("FAIL rst_busy_noack: acks=%0d, required 0", n_dr - b_dr);
    end
    tick();
    n_checks++;
    if (dc_read_ack !== 1'b1 || dc_read_data !== rd_line) begin
      n_fail++;
      $display("FAIL rst_busy_done: ack=%b data=%h, required 1 %h", dc_read_ack, dc_read_data, rd_line);
    end
    dc_read_req = 1'b0;
    tick();
    n_checks++;
    if (n_dr - b_dr != 1) begin
      n_fail++;
      $display("FAIL rst_busy_count: acks=%0d, required 1", n_dr - b_dr);
    end
    tick();
  endtask

  task automatic test_stray_ack();
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_checks++;
      if (mem_if.mem_enable !== 1'b0 || {ic_read_ack, dc_read_ack, dc_write_ack} !== 3'b000) begin
        n_fail++;
        $display("FAIL stray_ack c%0d: en=%b acks=%b, required 0 000", c, mem_if.mem_enable,
                 {ic_read_ack, dc_read_ack, dc_write_ack});
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    mem_wait     = 0;
    rd_line      = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A;
    dc_read_req  = 1'b1;
    dc_read_addr = 32'hA00;
    tick();
    tick();
    n_checks++;
    if (dc_read_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_ack: ack=%b, required 1", dc_read_ack);
    end
    tick();
    dc_read_addr = 32'hA40;
    // the re-asserted req is masked here, so two dead cycles follow the ack
    for (int c = 3; c <= 4; c++) begin
      n_checks++;
      if (mem_if.mem_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_gap c%0d: en=%b, required 0", c, mem_if.mem_enable);
      end
      tick();
    end
    n_checks++;
    if (mem_if.mem_enable !== 1'b1 || mem_if.mem_addr !== 32'hA40) begin
      n_fail++;
      $display("FAIL b2b_second: en=%b addr=%h, required 1 a40", mem_if.mem_enable, mem_if.mem_addr);
    end
    tick();
    n_checks++;
    if (dc_read_ack !== 1'b1 || dc_read_data !== rd_line) begin
      n_fail++;
      $display("FAIL b2b_second_ack: ack=%b data=%h, required 1 %h", dc_read_ack, dc_read_data, rd_line);
    end
    dc_read_req = 1'b0;
    tick();
    n_checks++;
    if (mem_if.mem_enable !== 1'b0 || dc_read_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: en=%b ack=%b, required 0 0", mem_if.mem_enable, dc_read_ack);
    end
    tick();
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    n_ic          = 0;
    n_dr          = 0;
    n_dw          = 0;
    reset         = 1'b1;
    ic_read_req   = 1'b0; ic_read_addr  = 32'h0;
    dc_read_req   = 1'b0; dc_read_addr  = 32'h0;
    dc_write_req  = 1'b0; dc_write_addr = 32'h0; dc_write_data = 128'h0;
    stray_ack     = 1'b0;
    model_ack     = 1'b0;
    rd_line       = 128'h0;
    model_rdata   = 128'h0;
    mem_wait      = 0;
    en_cnt        = 0;

    test_reset();
    test_ic_fill();
    test_write_back();
    test_all_three();
    test_starvation();
    test_reset_busy();
    test_stray_ack();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
